// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and bus widths for the memory stage
package mem_stage_pkg;

    localparam int WORD_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int INST_ADDR_W = 16;

    // Writeback source select carried in the EX bundle
    localparam logic [1:0] WB_FROM_ALU = 2'd0;
    localparam logic [1:0] WB_FROM_MEM = 2'd1;
    localparam logic [1:0] WB_FROM_PC  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX result capture, data-memory handshake and writeback register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_valid_i,
    input  logic                    mem_wen_i,
    input  logic [WORD_W-1:0]       mem_wdata_i,
    input  logic                    reg_wen_i,
    input  logic [REG_ADDR_W-1:0]   reg_waddr_i,
    input  logic [WORD_W-1:0]       alu_result_i,
    input  logic [1:0]              wb_sel_i,
    input  logic [INST_ADDR_W-1:0]  pc4_i,
    output logic                    stall_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [INST_ADDR_W-1:0]  dmem_addr_o,
    output logic [WORD_W-1:0]       dmem_wdata_o,
    input  logic                    dmem_ack_i,
    input  logic [WORD_W-1:0]       dmem_rdata_i,
    output logic                    wb_valid_o,
    output logic                    wb_reg_wen_o,
    output logic [REG_ADDR_W-1:0]   wb_reg_waddr_o,
    output logic [WORD_W-1:0]       wb_wdata_o,
    output logic [WORD_W-1:0]       data_forward_o,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_e                  state_q;
    logic [CNT_W-1:0]        wait_cnt_q;

    // Access captured at accept time; held stable for the whole request
    logic                    cap_we_q;
    logic [INST_ADDR_W-1:0]  cap_addr_q;
    logic [WORD_W-1:0]       cap_wdata_q;
    logic                    cap_reg_wen_q;
    logic [REG_ADDR_W-1:0]   cap_reg_waddr_q;

    logic                    wb_valid_q;
    logic                    wb_reg_wen_q;
    logic [REG_ADDR_W-1:0]   wb_reg_waddr_q;
    logic [WORD_W-1:0]       wb_wdata_q;
    logic                    err_q;

    logic                    is_mem_op;
    logic                    misaligned;
    logic [WORD_W-1:0]       alu_wb_data;

    // Classify the EX bundle and pick the non-memory writeback value
    always_comb begin
        is_mem_op   = mem_wen_i || (wb_sel_i == WB_FROM_MEM);
        misaligned  = (alu_result_i[1:0] != 2'b00);
        alu_wb_data = (wb_sel_i == WB_FROM_PC) ? {16'b0, pc4_i} : alu_result_i;
    end

    // Access FSM together with the registered writeback bundle and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= '0;
            cap_we_q        <= 1'b0;
            cap_addr_q      <= '0;
            cap_wdata_q     <= '0;
            cap_reg_wen_q   <= 1'b0;
            cap_reg_waddr_q <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_wen_q    <= 1'b0;
            wb_reg_waddr_q  <= '0;
            wb_wdata_q      <= '0;
            err_q           <= 1'b0;
        end else begin
            // Every path that does not produce a result leaves a bubble
            wb_valid_q     <= 1'b0;
            wb_reg_wen_q   <= 1'b0;
            wb_reg_waddr_q <= '0;
            wb_wdata_q     <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (inst_valid_i) begin
                        if (is_mem_op) begin
                            if (misaligned) begin
                                err_q <= 1'b1;
                            end else begin
                                cap_we_q        <= mem_wen_i;
                                cap_addr_q      <= {alu_result_i[15:2], 2'b00};
                                cap_wdata_q     <= mem_wdata_i;
                                cap_reg_wen_q   <= reg_wen_i;
                                cap_reg_waddr_q <= reg_waddr_i;
                                wait_cnt_q      <= '0;
                                state_q         <= ST_BUSY;
                            end
                        end else begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_wen_q   <= reg_wen_i;
                            wb_reg_waddr_q <= reg_waddr_i;
                            wb_wdata_q     <= alu_wb_data;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack_i) begin
                        state_q        <= ST_IDLE;
                        wb_valid_q     <= 1'b1;
                        wb_reg_waddr_q <= cap_reg_waddr_q;
                        // Stores retire without touching the register file
                        if (cap_we_q) begin
                            wb_reg_wen_q <= 1'b0;
                            wb_wdata_q   <= '0;
                        end else begin
                            wb_reg_wen_q <= cap_reg_wen_q;
                            wb_wdata_q   <= dmem_rdata_i;
                        end
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_o        = (state_q == ST_BUSY);
    assign dmem_req_o     = (state_q == ST_BUSY);
    assign dmem_we_o      = cap_we_q;
    assign dmem_addr_o    = cap_addr_q;
    assign dmem_wdata_o   = cap_wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_wen_o   = wb_reg_wen_q;
    assign wb_reg_waddr_o = wb_reg_waddr_q;
    assign wb_wdata_o     = wb_wdata_q;
    assign data_forward_o = wb_valid_q ? wb_wdata_q : '0;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        mem_wen_i = 1'b0;
    logic [31:0] mem_wdata_i = '0;
    logic        reg_wen_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic [31:0] alu_result_i = '0;
    logic [1:0]  wb_sel_i = '0;
    logic [15:0] pc4_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        wb_valid_o, wb_reg_wen_o;
    logic [4:0]  wb_reg_waddr_o;
    logic [31:0] wb_wdata_o, data_forward_o;
    logic        err_o;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .mem_wen_i(mem_wen_i), .mem_wdata_i(mem_wdata_i),
        .reg_wen_i(reg_wen_i), .reg_waddr_i(reg_waddr_i), .alu_result_i(alu_result_i),
        .wb_sel_i(wb_sel_i), .pc4_i(pc4_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_reg_wen_o(wb_reg_wen_o), .wb_reg_waddr_o(wb_reg_waddr_o),
        .wb_wdata_o(wb_wdata_o), .data_forward_o(data_forward_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        valid;
        logic        mem_wen;
        logic [31:0] mwdata;
        logic        reg_wen;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [1:0]  sel;
        logic [15:0] pc4;
    } op_t;

    typedef struct {
        op_t         op;
        int          delay;
        logic [31:0] rdata;
        logic        e_valid;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic        e_req;
        logic        e_err;
    } vec_t;

    vec_t tbl [8];
    logic model_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input op_t o);
        inst_valid_i = o.valid;
        mem_wen_i    = o.mem_wen;
        mem_wdata_i  = o.mwdata;
        reg_wen_i    = o.reg_wen;
        reg_waddr_i  = o.waddr;
        alu_result_i = o.alu;
        wb_sel_i     = o.sel;
        pc4_i        = o.pc4;
    endtask

    function automatic op_t mk(input logic v, input logic mw, input logic [31:0] md,
                               input logic rw, input logic [4:0] ra, input logic [31:0] alu,
                               input logic [1:0] sel, input logic [15:0] pc4);
        op_t o;
        o.valid = v; o.mem_wen = mw; o.mwdata = md; o.reg_wen = rw;
        o.waddr = ra; o.alu = alu; o.sel = sel; o.pc4 = pc4;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t o, input int d, input logic [31:0] rd,
                                 input logic ev, input logic ew, input logic [31:0] ed,
                                 input logic er, input logic ee);
        vec_t v;
        v.op = o; v.delay = d; v.rdata = rd; v.e_valid = ev; v.e_wen = ew;
        v.e_wdata = ed; v.e_req = er; v.e_err = ee;
        return v;
    endfunction

    function automatic op_t bubble_op();
        return mk(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, WB_FROM_ALU, 16'h0);
    endfunction

    // Check the writeback bundle against expectations
    task automatic chk_wb(input string tag, input vec_t v);
        chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'(v.e_valid));
        chk({tag, ".wb_wen"}, 32'(wb_reg_wen_o), 32'(v.e_valid & v.e_wen));
        if (v.e_valid) chk({tag, ".wb_wdata"}, wb_wdata_o, v.e_wdata);
        if (v.e_valid && v.e_wen) chk({tag, ".wb_waddr"}, 32'(wb_reg_waddr_o), 32'(v.op.waddr));
        chk({tag, ".forward"}, data_forward_o, v.e_valid ? v.e_wdata : 32'h0);
    endtask

    // Present one instruction, serve its memory access, check the outcome
    task automatic run_op(input string tag, input vec_t v, input logic idle_ack);
        int  stall_cnt;
        bit  done;
        drive(v.op);
        dmem_ack_i   = idle_ack;
        dmem_rdata_i = $urandom;
        chk({tag, ".idle_stall"}, 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        drive(bubble_op());
        if (!v.e_req) begin
            chk({tag, ".req"}, 32'(dmem_req_o), 32'h0);
            chk({tag, ".stall"}, 32'(stall_o), 32'h0);
            chk_wb(tag, v);
        end else begin
            chk({tag, ".req"}, 32'(dmem_req_o), 32'h1);
            chk({tag, ".we"}, 32'(dmem_we_o), 32'(v.op.mem_wen));
            chk({tag, ".addr"}, 32'(dmem_addr_o), 32'(v.op.alu[15:0]));
            if (v.op.mem_wen) chk({tag, ".dwdata"}, dmem_wdata_o, v.op.mwdata);
            chk({tag, ".busy_wb"}, 32'(wb_valid_o), 32'h0);
            stall_cnt = 0;
            done = 1'b0;
            for (int k = 0; k <= MW && !done; k++) begin
                if (stall_o) stall_cnt++;
                if (k == v.delay) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = v.rdata;
                end
                @(posedge clk); #1;
                dmem_ack_i = 1'b0;
                if (k == v.delay) done = 1'b1;
            end
            chk({tag, ".stall_cycles"}, 32'(stall_cnt),
                (v.delay <= MW) ? 32'(v.delay + 1) : 32'(MW + 1));
            chk({tag, ".req_after"}, 32'(dmem_req_o), 32'h0);
            chk({tag, ".stall_after"}, 32'(stall_o), 32'h0);
            chk_wb(tag, v);
        end
        chk({tag, ".err"}, 32'(err_o), 32'(v.e_err));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(bubble_op());
        dmem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", 32'(stall_o), 32'h0);
        chk("reset.req", 32'(dmem_req_o), 32'h0);
        chk("reset.wb_valid", 32'(wb_valid_o), 32'h0);
        chk("reset.wb_wdata", wb_wdata_o, 32'h0);
        chk("reset.err", 32'(err_o), 32'h0);
        rst = 1'b1;
        model_err = 1'b0;
    endtask

    // Reference: outcome of one instruction from the stage's architectural rules
    function automatic vec_t model(input op_t o, input int d, input logic [31:0] rd);
        vec_t v;
        logic mem = o.valid && (o.mem_wen || o.sel == WB_FROM_MEM);
        v = mkv(o, d, rd, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        if (!o.valid) begin
            // bubble
        end else if (mem) begin
            if (o.alu[1:0] != 2'b00) begin
                model_err = 1'b1;
            end else begin
                v.e_req = 1'b1;
                if (d > MW) model_err = 1'b1;
                else if (o.mem_wen) v.e_valid = 1'b1;
                else begin
                    v.e_valid = 1'b1;
                    v.e_wen   = o.reg_wen;
                    v.e_wdata = rd;
                end
            end
        end else begin
            v.e_valid = 1'b1;
            v.e_wen   = o.reg_wen;
            v.e_wdata = (o.sel == WB_FROM_PC) ? {16'h0, o.pc4} : o.alu;
        end
        v.e_err = model_err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        op_t  o;
        tbl[0] = mkv(mk(1, 0, 0, 1, 5'd5, 32'h1234, WB_FROM_ALU, 16'h0), 0, 0, 1, 1, 32'h1234, 0, 0);
        tbl[1] = mkv(mk(1, 0, 0, 1, 5'd7, 32'hFFFF0003, WB_FROM_PC, 16'h0040), 0, 0, 1, 1, 32'h40, 0, 0);
        tbl[2] = mkv(mk(1, 0, 0, 1, 5'd9, 32'h0010, WB_FROM_MEM, 16'h0), 2, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 0);
        tbl[3] = mkv(mk(1, 1, 32'hA5A5A5A5, 0, 5'd3, 32'h0008, WB_FROM_ALU, 16'h0), 0, 0, 1, 0, 32'h0, 1, 0);
        tbl[4] = mkv(mk(0, 1, 32'h1, 1, 5'd4, 32'h0003, WB_FROM_MEM, 16'h0), 0, 0, 0, 0, 32'h0, 0, 0);
        tbl[5] = mkv(mk(1, 0, 0, 0, 5'd6, 32'h0003, WB_FROM_ALU, 16'h0), 0, 0, 1, 0, 32'h3, 0, 0);
        tbl[6] = mkv(mk(1, 0, 0, 0, 5'd8, 32'h0020, WB_FROM_MEM, 16'h0), MW, 32'h12345678, 1, 0, 32'h12345678, 1, 0);
        tbl[7] = mkv(mk(1, 0, 0, 1, 5'd2, 32'h0006, WB_FROM_MEM, 16'h0), 0, 0, 0, 0, 32'h0, 0, 1);

        do_reset();
        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Timeout needs a clean sticky error to be observable
        do_reset();
        run_op("timeout", mkv(mk(1, 0, 0, 1, 5'd1, 32'h0030, WB_FROM_MEM, 16'h0), MW + 1, 0,
                              0, 0, 0, 1, 1), 1'b0);

        // EX instruction held during a stall is accepted the cycle after the ack
        do_reset();
        drive(mk(1, 0, 0, 1, 5'd9, 32'h0010, WB_FROM_MEM, 16'h0));
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 1, 5'd11, 32'h00C0FFEE, WB_FROM_ALU, 16'h0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        chk("held.load_wdata", wb_wdata_o, 32'hDEADBEEF);
        chk("held.load_waddr", 32'(wb_reg_waddr_o), 32'd9);
        chk("held.stall_low", 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        drive(bubble_op());
        chk("held.next_valid", 32'(wb_valid_o), 32'h1);
        chk("held.next_wdata", wb_wdata_o, 32'h00C0FFEE);
        chk("held.next_waddr", 32'(wb_reg_waddr_o), 32'd11);

        // Asynchronous reset in the middle of an access
        drive(mk(1, 0, 0, 1, 5'd9, 32'h0040, WB_FROM_MEM, 16'h0));
        @(posedge clk); #1;
        drive(bubble_op());
        @(posedge clk); #3;
        chk("arst.req_before", 32'(dmem_req_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst.req_async", 32'(dmem_req_o), 32'h0);
        chk("arst.stall_async", 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h55AA55AA;
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst.req_after", 32'(dmem_req_o), 32'h0);
            chk("arst.wb_valid", 32'(wb_valid_o), 32'h0);
            chk("arst.err", 32'(err_o), 32'h0);
        end
        dmem_ack_i = 1'b0;

        // Randomised traffic against the reference model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int d;
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            o = mk(($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0), $urandom,
                   1'($urandom), 5'($urandom), a, 2'($urandom_range(0, 3)), 16'($urandom));
            d = ($urandom_range(0, 9) == 0) ? MW + 1 : $urandom_range(0, MW);
            v = model(o, d, $urandom);
            run_op($sformatf("rnd%0d", n), v, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
